timer_prog: RTL and testbench
=============================

# timer_prog

Programmable interval timer: the parametrised successor of the fixed-count debounce timer. Counting width and clock prescaling are set by parameters. The terminal count is loaded at run time. The timer runs either periodic or one-shot, with explicit start and stop controls. It supplies the sample strobes for the button debouncers and edge detectors, and any other fixed-interval pacing in the design.

## Interface
- `WIDTH`, 16, width of the period and count registers; must be ≥ 1.
- `PRESCALE`, 1, number of enabled clock cycles per count tick; must be ≥ 1. The prescaler register is max($clog2(PRESCALE), 1) bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; has priority over every other input.
- `enable`  in  1  count gate; when low, the prescaler and count freeze.
- `start`  in  1  single-cycle pulse; latches `period` and begins counting from 0.
- `stop`  in  1  single-cycle pulse; aborts the run and returns to IDLE.
- `mode`  in  1  0 = periodic, 1 = one-shot; sampled with `start`.
- `period`  in  WIDTH  terminal count P; sampled only when `start` is accepted.
- `done`  out  1  registered one-cycle pulse at each terminal tick.
- `busy`  out  1  high while in RUN.
- `count`  out  WIDTH  current count value, registered.

## Operation
- The timer has two states, IDLE and RUN. Internal registers: `period_r`, `mode_r`, prescaler `pre`, `count`.
- Per-edge priority: `reset` > `stop` > `start` > tick.
- **reset:** state = IDLE; `pre`, `count` and `period_r` are cleared; `done` = 0, `busy` = 0.
- **stop:** valid in any state. Goes to IDLE and clears `pre` and `count`. No `done` is produced, even if a terminal tick coincides.
- **start:** in IDLE or RUN, latches `period_r` ← `period` and `mode_r` ← `mode`, clears `pre` and `count`, and enters RUN. When `start` arrives during RUN, the timer restarts and no `done` is produced that edge.
- **Tick:** occurs when state = RUN, `enable` = 1 and `pre` == PRESCALE−1. On that edge `pre` ← 0. When `enable` = 1 without a tick, `pre` increments.
- **Tick with `count` ≠ `period_r`:** `count` ← `count` + 1.
- **Terminal tick (`count` == `period_r`):**
  - `count` ← 0 and `done` ← 1 for exactly one cycle.
  - Periodic mode stays in RUN.
  - One-shot mode goes to IDLE.
- **Interval length:** one interval is (P+1)·PRESCALE enabled cycles.
- **P = 0:** every tick is terminal.
- **Overflow:** `count` never exceeds `period_r`, so no wrap-around is possible. P = 2^WIDTH−1 is legal.
- **IDLE:** `count` holds 0 and `enable`/ticks are ignored.
- **`period` or `mode` changes during RUN** have no effect until the next `start`.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs. `busy` is decoded from the state register.
- **Reset values:** `done` = 0, `busy` = 0, `count` = 0.
- **Start edge (edge 0, `start` sampled):** `busy` = 1 and `count` = 0 from the following cycle.
- **Latency with `enable` held high:**
  - Ticks occur on edges k·PRESCALE, k ≥ 1.
  - `done` is high in the cycle after edge (P+1)·PRESCALE.
  - In periodic mode, `done` repeats every (P+1)·PRESCALE cycles.
- **`enable` low:** each low cycle extends the interval by exactly one cycle. The prescaler phase is preserved.
- **One-shot:** `busy` falls on the same edge that raises `done`.
- **Stop/reset during RUN:** `busy` = 0 and `count` = 0 from the next cycle. No `done` follows.

## Test plan
- **Reset:** WIDTH=8, PRESCALE=1; hold `reset` 3 cycles with `start` = 1 -> `done` = 0, `busy` = 0, `count` = 0 throughout. After release, idle 10 cycles -> no `done`.
- **Periodic:** P=4, PRESCALE=1, `enable` = 1, `start` at edge 0 -> `count` sequence 0,1,2,3,4,0…; `done` high after edges 5, 10, 15; `busy` stays 1.
- **One-shot with prescaler:** PRESCALE=3, P=2, `mode` = 1 -> single `done` after edge 9; `busy` falls at edge 9; `count` = 0 afterwards with no further `done` over 30 cycles.
- **Enable gating:** P=3, PRESCALE=2, `enable` low for 4 cycles mid-run -> `done` after edge 12 instead of 8; `count` frozen while low.
- **Simultaneous events:**
  - `stop` coincident with the terminal tick (P=2) -> no `done`, IDLE.
  - `start` with P=5 asserted at `count` = 1 of a P=2 run -> restart with no `done`; next `done` 6 cycles later.
- **Boundaries:** P=0, PRESCALE=1 -> `done` every cycle after start. P=255, WIDTH=8 -> `done` after edge 256 and `count` returns to 0 with no overflow.

Source files
------------

// File: rtl/timer_prog.sv
// timer_prog -- programmable interval timer.
//
// Counts prescaled ticks from 0 up to a run-time terminal count P and raises
// a one-cycle done pulse on the terminal tick. Periodic mode (mode = 0)
// restarts from 0 after each terminal tick; one-shot mode (mode = 1) returns
// to IDLE. One interval lasts (P+1)*PRESCALE enabled cycles.
//
// Parameters:
//   WIDTH     width of the period and count registers (>= 1)
//   PRESCALE  enabled clock cycles per count tick (>= 1)
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset, highest priority
//   enable  in   count gate; prescaler and count freeze while low
//   start   in   pulse: latch period/mode, clear count, enter RUN
//   stop    in   pulse: abort run, return to IDLE (beats start)
//   mode    in   0 = periodic, 1 = one-shot; sampled with start
//   period  in   terminal count P; sampled with start
//   done    out  registered one-cycle pulse on each terminal tick
//   busy    out  high while in RUN
//   count   out  current count value, registered
module timer_prog #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam int          PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] period_r;
  logic             mode_r;
  logic [PW-1:0]    pre;

  // Tick and terminal-tick decode from the current registered state.
  logic tick;
  logic terminal;

  assign tick     = (state == RUN) && enable && (pre == PRE_LAST);
  assign terminal = tick && (count == period_r);

  // Single state register stage: stop beats start beats tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      period_r <= '0;
      mode_r   <= 1'b0;
      pre      <= '0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        pre   <= '0;
        count <= '0;
      end else if (start) begin
        // A restart during RUN discards the run in progress, so no done here.
        state    <= RUN;
        period_r <= period;
        mode_r   <= mode;
        pre      <= '0;
        count    <= '0;
      end else if ((state == RUN) && enable) begin
        if (tick) begin
          pre <= '0;
          if (terminal) begin
            count <= '0;
            done  <= 1'b1;
            if (mode_r) begin
              state <= IDLE;
            end
          end else begin
            // count stays <= period_r, so this increment cannot wrap.
            count <= count + WIDTH'(1);
          end
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_timer_prog.sv
module tb_timer_prog;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] period;

  logic       done1, busy1;
  logic [7:0] count1;
  logic       done2, busy2;
  logic [7:0] count2;
  logic       done3, busy3;
  logic [7:0] count3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic       done;
    logic       busy;
    logic [7:0] count;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  timer_prog #(.WIDTH(8), .PRESCALE(1)) u_ps1 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .period(period), .done(done1), .busy(busy1), .count(count1)
  );

  timer_prog #(.WIDTH(8), .PRESCALE(2)) u_ps2 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .period(period), .done(done2), .busy(busy2), .count(count2)
  );

  timer_prog #(.WIDTH(8), .PRESCALE(3)) u_ps3 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
    .mode(mode), .period(period), .done(done3), .busy(busy3), .count(count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Outputs settle after the rising edge; compare them on the falling edge.
  always @(negedge clk) begin
    exp_t  it;
    string tg;
    logic  d, b;
    logic [7:0] c;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      tg = tag_q.pop_front();
      case (it.sel)
        2'd2:    begin d = done2; b = busy2; c = count2; end
        2'd3:    begin d = done3; b = busy3; c = count3; end
        default: begin d = done1; b = busy1; c = count1; end
      endcase
      check({tg, ".done"},  int'(d), int'(it.done));
      check({tg, ".busy"},  int'(b), int'(it.busy));
      check({tg, ".count"}, int'(c), int'(it.count));
    end
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel, input int d, input int b, input int c,
                      input string tag);
    exp_t it;
    it.sel   = 2'(sel);
    it.done  = d[0];
    it.busy  = b[0];
    it.count = 8'(c);
    exp_q.push_back(it);
    tag_q.push_back(tag);
  endtask

  // Periodic, enable held high, e edges after the start edge.
  task automatic push_per(input int sel, input int e, input int p, input int ps,
                          input string tag);
    int iv;
    iv = (p + 1) * ps;
    push(sel, (e > 0 && (e % iv) == 0) ? 1 : 0, 1, (e / ps) % (p + 1),
         $sformatf("%s e%0d", tag, e));
  endtask

  // One-shot, enable held high, e edges after the start edge.
  task automatic push_one(input int sel, input int e, input int p, input int ps,
                          input string tag);
    int iv;
    iv = (p + 1) * ps;
    if (e < iv)       push(sel, 0, 1, e / ps, $sformatf("%s e%0d", tag, e));
    else if (e == iv) push(sel, 1, 0, 0, $sformatf("%s e%0d", tag, e));
    else              push(sel, 0, 0, 0, $sformatf("%s e%0d", tag, e));
  endtask

  task automatic do_stop(input int sel);
    stop = 1'b1;
    next_edge();
    stop = 1'b0;
    push(sel, 0, 0, 0, "stop");
  endtask

  task automatic do_start(input logic [7:0] p, input logic m);
    period = p;
    mode   = m;
    start  = 1'b1;
    next_edge();
    start  = 1'b0;
  endtask

  initial begin
    int en;
    reset  = 1'b1;
    start  = 1'b1;
    stop   = 1'b0;
    mode   = 1'b0;
    enable = 1'b1;
    period = 8'd3;

    // Reset held with start asserted, then idle.
    repeat (3) begin
      next_edge();
      push(1, 0, 0, 0, "reset");
    end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_edge();
      push(1, 0, 0, 0, $sformatf("idle%0d", i));
    end

    // Periodic, P=4, PRESCALE=1.
    do_start(8'd4, 1'b0);
    push_per(1, 0, 4, 1, "per4");
    for (int e = 1; e <= 16; e++) begin
      next_edge();
      push_per(1, e, 4, 1, "per4");
    end
    do_stop(1);

    // One-shot, P=2, PRESCALE=3.
    do_start(8'd2, 1'b1);
    push_one(3, 0, 2, 3, "one");
    for (int e = 1; e <= 39; e++) begin
      next_edge();
      push_one(3, e, 2, 3, "one");
    end

    // Enable gating, P=3, PRESCALE=2, enable low for edges 3..6.
    do_start(8'd3, 1'b0);
    push(2, 0, 1, 0, "gate e0");
    for (int e = 1; e <= 13; e++) begin
      enable = !(e >= 3 && e <= 6);
      next_edge();
      en = e - (((e < 6) ? e : 6) > 2 ? (((e < 6) ? e : 6) - 2) : 0);
      push(2, (enable && en > 0 && (en % 8) == 0) ? 1 : 0, 1, (en / 2) % 4,
           $sformatf("gate e%0d", e));
    end
    enable = 1'b1;
    do_stop(2);

    // Stop coincident with terminal tick, P=2.
    do_start(8'd2, 1'b0);
    push_per(1, 0, 2, 1, "stopterm");
    for (int e = 1; e <= 2; e++) begin
      next_edge();
      push_per(1, e, 2, 1, "stopterm");
    end
    stop = 1'b1;
    next_edge();
    stop = 1'b0;
    push(1, 0, 0, 0, "stopterm e3");
    for (int i = 0; i < 5; i++) begin
      next_edge();
      push(1, 0, 0, 0, $sformatf("stopterm idle%0d", i));
    end

    // Restart with P=5 while a P=2 run sits at count 1.
    do_start(8'd2, 1'b0);
    push_per(1, 0, 2, 1, "pre_restart");
    next_edge();
    push_per(1, 1, 2, 1, "pre_restart");
    do_start(8'd5, 1'b0);
    push(1, 0, 1, 0, "restart");
    for (int e = 1; e <= 8; e++) begin
      next_edge();
      push_per(1, e, 5, 1, "restart5");
    end
    do_stop(1);

    // P=0: done on every cycle after start.
    do_start(8'd0, 1'b0);
    push_per(1, 0, 0, 1, "p0");
    for (int e = 1; e <= 6; e++) begin
      next_edge();
      push_per(1, e, 0, 1, "p0");
    end
    do_stop(1);

    // P=255 with an 8-bit counter: full range, no overflow.
    do_start(8'd255, 1'b0);
    push_per(1, 0, 255, 1, "p255");
    for (int e = 1; e <= 258; e++) begin
      next_edge();
      push_per(1, e, 255, 1, "p255");
    end
    do_stop(1);

    next_edge();
    next_edge();
    check("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
